// File: rtl/bfp_dot_accum.sv
// Accumulates a run of unsigned PE partial dot products into a saturating wide
// accumulator and presents the block mantissa sum with the combined shared exponent.
//
// state    | meaning
// ACCUM    | accepting partial-sum beats, building the running sum
// HOLD     | result presented on dn_*, waiting for dn_rdy
module bfp_dot_accum #(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 32,
    parameter int EXP_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic [EXP_WIDTH-1:0] exp_a,
    input  logic [EXP_WIDTH-1:0] exp_b,
    input  logic                 up_vld,
    input  logic [IN_WIDTH-1:0]  up_dat,
    output logic                 up_rdy,
    output logic                 dn_vld,
    output logic [ACC_WIDTH-1:0] dn_dat,
    output logic [EXP_WIDTH:0]   dn_exp,
    output logic                 dn_ovf,
    input  logic                 dn_rdy
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len;
    logic [ACC_WIDTH-1:0] acc;
    logic [EXP_WIDTH:0]   exp_sum;
    logic                 ovf;

    logic                 beat;
    logic                 first;
    logic                 last;
    logic [CNT_WIDTH-1:0] len_eff;
    logic [CNT_WIDTH-1:0] len_now;
    logic [ACC_WIDTH-1:0] dat_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [EXP_WIDTH:0]   exp_new;

    assign up_rdy  = (state == ST_ACCUM);
    assign beat    = up_vld && up_rdy;
    assign first   = (cnt == '0);
    assign len_eff = (cfg_len == '0) ? CNT_ONE : cfg_len;
    // The length in force is the live config on the first beat, the latched one afterwards.
    assign len_now = first ? len_eff : len;
    assign last    = (cnt == (len_now - CNT_ONE));
    assign dat_ext = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, up_dat};
    assign sum     = {1'b0, acc} + {1'b0, dat_ext};
    assign exp_new = {exp_a[EXP_WIDTH-1], exp_a} + {exp_b[EXP_WIDTH-1], exp_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ACCUM;
            cnt     <= '0;
            len     <= '0;
            acc     <= '0;
            exp_sum <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (beat) begin
                        if (first) begin
                            acc     <= dat_ext;
                            len     <= len_eff;
                            exp_sum <= exp_new;
                            ovf     <= 1'b0;
                        end else if (sum[ACC_WIDTH]) begin
                            // Saturate; later adds keep carrying out so acc stays pinned.
                            acc <= '1;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum[ACC_WIDTH-1:0];
                        end
                        if (last) begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (dn_rdy) begin
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    assign dn_vld = (state == ST_HOLD);
    assign dn_dat = acc;
    assign dn_exp = exp_sum;
    assign dn_ovf = ovf;

endmodule

// File: tb/tb_bfp_dot_accum.sv
// Bench for bfp_dot_accum: directed scenarios plus randomized runs, all checked
// against a run-level model (plain sum with saturation) evaluated every cycle.
module tb_bfp_dot_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        up_vld;
    logic [17:0] up_dat;
    logic        up_rdy;
    logic        dn_vld;
    logic [31:0] dn_dat;
    logic [8:0]  dn_exp;
    logic        dn_ovf;
    logic        dn_rdy;

    logic [7:0]  s_cfg_len;
    logic        s_up_vld;
    logic [17:0] s_up_dat;
    logic        s_up_rdy;
    logic        s_dn_vld;
    logic [19:0] s_dn_dat;
    logic [8:0]  s_dn_exp;
    logic        s_dn_ovf;
    logic        s_dn_rdy;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;
    int n_results = 0;
    int exp_results = 0;

    // run-level model state
    bit     m_valid = 1'b0;
    bit     m_hold = 1'b0;
    int     m_cnt = 0;
    int     m_len = 1;
    int     m_exp = 0;
    longint m_total = 0;
    localparam longint MAXV = 64'hFFFF_FFFF;

    always #5 clk = ~clk;

    bfp_dot_accum u_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .exp_a(exp_a), .exp_b(exp_b),
        .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy),
        .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_exp(dn_exp), .dn_ovf(dn_ovf),
        .dn_rdy(dn_rdy)
    );

    bfp_dot_accum #(.ACC_WIDTH(20)) u_sat (
        .clk(clk), .rst(rst), .cfg_len(s_cfg_len), .exp_a(exp_a), .exp_b(exp_b),
        .up_vld(s_up_vld), .up_dat(s_up_dat), .up_rdy(s_up_rdy),
        .dn_vld(s_dn_vld), .dn_dat(s_dn_dat), .dn_exp(s_dn_exp), .dn_ovf(s_dn_ovf),
        .dn_rdy(s_dn_rdy)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: at each negedge, compare outputs, then predict the effect of the next posedge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("up_rdy", longint'(up_rdy), longint'(!m_hold));
            check("dn_vld", longint'(dn_vld), longint'(m_hold));
            if (m_hold) begin
                check("dn_dat", longint'(dn_dat), (m_total > MAXV) ? MAXV : m_total);
                check("dn_ovf", longint'(dn_ovf), longint'(m_total > MAXV));
                check("dn_exp", longint'($signed(dn_exp)), longint'(m_exp));
            end
        end
        if (rst) begin
            m_valid = 1'b1;
            m_hold  = 1'b0;
            m_cnt   = 0;
        end else if (m_valid) begin
            if (!m_hold && up_vld) begin
                if (m_cnt == 0) begin
                    m_len   = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_exp   = int'($signed(exp_a)) + int'($signed(exp_b));
                    m_total = longint'(up_dat);
                end else begin
                    m_total += longint'(up_dat);
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_hold = 1'b1;
                    m_cnt  = 0;
                    n_results++;
                end
            end else if (m_hold && dn_rdy) begin
                m_hold = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        dn_rdy = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(0, 1) == 1));
    end

    task automatic send_beat(input logic [17:0] d);
        bit done = 1'b0;
        up_vld = 1'b1;
        up_dat = d;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = up_rdy;
            @(posedge clk);
            #1;
        end
        up_vld = 1'b0;
        if (!done) check("beat_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; cfg_len = 8'd0; exp_a = 8'd0; exp_b = 8'd0;
        up_vld = 1'b0; up_dat = '0; dn_rdy = 1'b1;
        s_cfg_len = 8'd0; s_up_vld = 1'b0; s_up_dat = '0; s_dn_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dat", longint'(dn_dat), 0);
        check("rst_exp", longint'(dn_exp), 0);
        check("rst_ovf", longint'(dn_ovf), 0);
        check("rst_sat_vld", longint'(s_dn_vld), 0);
        @(posedge clk); #1;

        // four back-to-back beats, mixed-sign exponents
        cfg_len = 8'd4; exp_a = 8'hFD; exp_b = 8'd2;
        send_beat(18'd10); send_beat(18'd20); send_beat(18'd30); send_beat(18'd40);
        exp_results += 1;
        @(negedge clk);
        check("t1_vld", longint'(dn_vld), 1);
        check("t1_dat", longint'(dn_dat), 100);
        check("t1_exp", longint'($signed(dn_exp)), -1);
        @(posedge clk); #1;

        // cfg_len 0 behaves as 1
        cfg_len = 8'd0; exp_a = 8'd0; exp_b = 8'd0;
        send_beat(18'd7);
        @(negedge clk); check("t2_dat7", longint'(dn_dat), 7);
        @(posedge clk); #1;
        send_beat(18'd9);
        @(negedge clk); check("t2_dat9", longint'(dn_dat), 9);
        @(posedge clk); #1;
        exp_results += 2;

        // stalled downstream: result held, pending beat not consumed
        rdy_mode = 0;
        cfg_len = 8'd3;
        send_beat(18'd1); send_beat(18'd2); send_beat(18'd3);
        up_vld = 1'b1; up_dat = 18'd99;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_dat", longint'(dn_dat), 6);
            check("t3_hold_rdy", longint'(up_rdy), 0);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        send_beat(18'd99); send_beat(18'd1); send_beat(18'd1);
        @(negedge clk); check("t3_next_dat", longint'(dn_dat), 101);
        @(posedge clk); #1;
        exp_results += 2;

        // reset mid-run discards partial sum
        cfg_len = 8'd4;
        send_beat(18'd5); send_beat(18'd6);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rdy", longint'(up_rdy), 1);
        check("t5_vld", longint'(dn_vld), 0);
        check("t5_dat", longint'(dn_dat), 0);
        @(posedge clk); #1;
        repeat (4) send_beat(18'd1);
        @(negedge clk); check("t5_sum", longint'(dn_dat), 4);
        @(posedge clk); #1;
        exp_results += 1;

        // config changes after the first beat are ignored; max exponents
        cfg_len = 8'd3; exp_a = 8'd127; exp_b = 8'd127;
        send_beat(18'd1);
        cfg_len = 8'd1; exp_a = 8'hFB; exp_b = 8'd0;
        repeat (2) @(posedge clk); #1;
        send_beat(18'd2);
        repeat (3) @(posedge clk); #1;
        send_beat(18'd3);
        @(negedge clk);
        check("t6_dat", longint'(dn_dat), 6);
        check("t6_exp", longint'($signed(dn_exp)), 254);
        @(posedge clk); #1;
        exp_results += 1;

        // randomized runs with random downstream backpressure
        rdy_mode = 2;
        for (int r = 0; r < 40; r++) begin
            int len;
            cfg_len = 8'($urandom_range(0, 6));
            exp_a = 8'($urandom);
            exp_b = 8'($urandom);
            len = (cfg_len == 0) ? 1 : int'(cfg_len);
            for (int b = 0; b < len; b++) begin
                send_beat(18'($urandom_range(0, 262143)));
                if (b == 0 && $urandom_range(0, 3) == 0) begin
                    cfg_len = 8'($urandom_range(0, 6));
                    exp_a = 8'($urandom);
                end
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            exp_results += 1;
        end
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        check("drained", longint'(m_hold), 0);
        check("results", longint'(n_results), longint'(exp_results));

        // narrow accumulator saturation and sticky-until-next-run overflow
        s_cfg_len = 8'd8; s_up_vld = 1'b1; s_up_dat = 18'h3FFFF;
        repeat (8) @(posedge clk);
        #1 s_up_vld = 1'b0;
        @(negedge clk);
        check("sat_vld", longint'(s_dn_vld), 1);
        check("sat_dat", longint'(s_dn_dat), 1048575);
        check("sat_ovf", longint'(s_dn_ovf), 1);
        @(posedge clk); #1 s_dn_rdy = 1'b1;
        @(posedge clk); #1 s_dn_rdy = 1'b0;
        s_cfg_len = 8'd1; s_up_vld = 1'b1; s_up_dat = 18'd5;
        @(posedge clk); #1 s_up_vld = 1'b0;
        @(negedge clk);
        check("sat2_vld", longint'(s_dn_vld), 1);
        check("sat2_dat", longint'(s_dn_dat), 5);
        check("sat2_ovf", longint'(s_dn_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
